axi_cache_bridge: RTL and testbench
===================================

# axi_cache_bridge

Parametrised AXI4 master bridge between the cache layer and the SoC AXI interconnect, next generation of the single-icache/uncached-data bridge. It serves NUM_RD independent read requesters (icache, dcache, uncached port) with round-robin arbitration on the AR channel, plus one write requester (dcache write-back or uncached store) with single-word or full-line burst writes. A write→read line-address conflict check prevents reads overtaking pending writes.

## Interface
- NUM_RD, 2: number of read requesters, 1..15; requester i uses AXI ID i.
- LINE_WORDS, 4: words per cache line, power of two, 2..16; line burst arlen/awlen = LINE_WORDS-1.
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- rd_req  in  NUM_RD  per-requester read request.
- rd_type  in  3*NUM_RD  3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line; others illegal.
- rd_addr  in  32*NUM_RD  read address; slice i = [32i+31:32i].
- rd_rdy  out  NUM_RD  requester i may issue.
- ret_valid  out  NUM_RD  return beat for requester i.
- ret_last  out  1  last beat of current return.
- ret_data  out  32  return data, shared by all requesters.
- wr_req, wr_type(3), wr_addr(32), wr_wstrb(4), wr_data(32*LINE_WORDS)  in  write request; word 0 in bits [31:0].
- wr_rdy  out  1  write port idle.
- wr_done  out  1  one-cycle pulse on B handshake.
- AXI AR/R/AW/W/B channels: 4-bit IDs, 32-bit data, standard directions, as in the current top.

## Operation
- Read capture: rd_req[i] & rd_rdy[i] latches addr/type into slot i; slot i pending. rd_rdy[i]=0 from capture until the R beat with rid==i and rlast is accepted.
- AR FSM: AR_IDLE -> AR_SEL -> AR_VALID -> AR_IDLE.
  - AR_IDLE: if any slot pending and not yet issued, grant = first pending index at or after rr_ptr (wrapping); go AR_SEL.
  - AR_SEL: if conflict, stay; else AR_VALID.
  - AR_VALID: arvalid=1, fields stable until arready; on handshake mark slot issued, rr_ptr <= grant+1 mod NUM_RD, go AR_IDLE.
- AR fields: arid=grant; line: arlen=LINE_WORDS-1, arsize=2, araddr=addr with low log2(4*LINE_WORDS) bits zeroed; single: arlen=0, arsize=type[1:0], araddr=addr. arburst=01, arlock/arcache/arprot=0.
- R: rready=1. ret_valid[i]=rvalid & rid==i; ret_data=rdata; ret_last=rlast. rresp ignored.
- Write FSM: W_IDLE -> W_BUSY -> W_RESP -> W_IDLE. wr_rdy=(state==W_IDLE). On wr_req & wr_rdy latch all fields, beat counter=0, go W_BUSY.
  - W_BUSY: awvalid until AW handshake, wvalid until last W handshake, independently. wdata=buffer word[cnt]; wstrb=4'hF for line, latched wr_wstrb otherwise; wlast on final beat. Both done -> W_RESP.
  - W_RESP: bready=1; bvalid -> W_IDLE, wr_done=1 that cycle.
- AW fields: awid=wid=NUM_RD; line: awlen=LINE_WORDS-1, awsize=2, line-aligned address; single: awlen=0, awsize=wr_type[1:0].
- Conflict: write state != W_IDLE and line address of granted read equals line address of write buffer.

## Timing
- Reset values: arvalid, awvalid, wvalid, wr_done, ret_valid all 0; rd_rdy all 0 during reset, all 1 the cycle after; wr_rdy 0 during reset; rr_ptr=0; bready=rready=1.
- Minimum read latency: capture cycle N, arvalid at N+2.
- Write: capture N, awvalid and wvalid at N+1; wr_rdy high again the cycle after B handshake.
- Once asserted, arvalid/awvalid/wvalid never drop and fields never change before handshake; conflict is checked only in AR_SEL.
- Write captured while a read is already in AR_VALID does not retract it (the read is older).
- Simultaneous AW and first W handshakes in one cycle are legal; a single-word write can reach W_RESP at N+2.
- Responses from different IDs may interleave; routing is purely by rid.
- Reset mid-transaction discards all slots and buffers.

## Test plan
- Single icache line read, addr 0x1C00_0014: arid 0, araddr 0x1C00_0010, arlen 3; 4 R beats -> ret_valid[0] ×4, ret_last on 4th, rd_rdy[0] back to 1.
- Requesters 0 and 1 request in the same cycle with rr_ptr=0: AR order ID 0 then ID 1; next simultaneous pair issues 1 then 0.
- Line write 0x0000_1000 data 0x11..0x44, awready delayed 3 cycles, wready always 1: 4 W beats, wlast on 0x44, wr_done on bvalid.
- Word read 0x0000_1008 while the line write above awaits B: no arvalid until after bvalid, then araddr 0x0000_1008, arlen 0, arsize 2.
- Byte write wstrb 4'b0100 at 0x80 followed by read of 0x100 (other line): read issues without waiting for B.
- Reset asserted during an R burst: all valids 0; rd_rdy=1 the cycle after release.

Source files
------------

// File: rtl/axi_cache_bridge.sv
// AXI4 master bridge: round-robin AR arbitration over NUM_RD cache read requesters,
// one single-word/line write port, and a hold on reads that hit a pending write's line.
module axi_cache_bridge #(
  parameter int NUM_RD     = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_RD-1:0]         i_rd_req,
  input  logic [3*NUM_RD-1:0]       i_rd_type,
  input  logic [32*NUM_RD-1:0]      i_rd_addr,
  output logic [NUM_RD-1:0]         o_rd_rdy,
  output logic [NUM_RD-1:0]         o_ret_valid,
  output logic                      o_ret_last,
  output logic [31:0]               o_ret_data,
  input  logic                      i_wr_req,
  input  logic [2:0]                i_wr_type,
  input  logic [31:0]               i_wr_addr,
  input  logic [3:0]                i_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]  i_wr_data,
  output logic                      o_wr_rdy,
  output logic                      o_wr_done,
  output logic [3:0]                o_arid,
  output logic [31:0]               o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic                      o_arlock,
  output logic [3:0]                o_arcache,
  output logic [2:0]                o_arprot,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [3:0]                i_rid,
  input  logic [31:0]               i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  output logic [3:0]                o_awid,
  output logic [31:0]               o_awaddr,
  output logic [7:0]                o_awlen,
  output logic [2:0]                o_awsize,
  output logic [1:0]                o_awburst,
  output logic                      o_awlock,
  output logic [3:0]                o_awcache,
  output logic [2:0]                o_awprot,
  output logic                      o_awvalid,
  input  logic                      i_awready,
  output logic [3:0]                o_wid,
  output logic [31:0]               o_wdata,
  output logic [3:0]                o_wstrb,
  output logic                      o_wlast,
  output logic                      o_wvalid,
  input  logic                      i_wready,
  input  logic [3:0]                i_bid,
  input  logic [1:0]                i_bresp,
  input  logic                      i_bvalid,
  output logic                      o_bready
);

  localparam int              LB        = $clog2(4 * LINE_WORDS);
  localparam int              CW        = $clog2(LINE_WORDS);
  localparam logic [31:0]     LINE_MASK = ~((32'd1 << LB) - 32'd1);
  localparam logic [7:0]      LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [3:0]      WR_ID     = 4'(NUM_RD);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {AR_IDLE, AR_SEL, AR_VALID} ar_state_e;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_e;

  ar_state_e         r_ar_state, w_ar_next;
  w_state_e          r_w_state, w_w_next;

  logic              r_alive;
  logic [NUM_RD-1:0] r_pending, r_issued;
  logic [31:0]       r_rd_addr [NUM_RD];
  logic [2:0]        r_rd_type [NUM_RD];
  logic [3:0]        r_grant, r_rr_ptr;

  logic [2:0]        r_wr_type;
  logic [31:0]       r_wr_addr;
  logic [3:0]        r_wr_wstrb;
  logic [31:0]       r_wbuf [LINE_WORDS];
  logic [CW-1:0]     r_cnt;
  logic              r_aw_done, r_w_done;

  logic [NUM_RD-1:0] w_cap, w_want, w_r_done;
  logic [3:0]        w_grant_sel;
  logic              w_grant_found;
  logic [31:0]       w_g_addr;
  logic [2:0]        w_g_type;
  logic              w_conflict, w_ar_hs, w_aw_hs, w_w_hs, w_wr_cap, w_aw_fin, w_w_fin;
  logic              w_unused;

  assign w_unused   = ^{i_rresp, i_bid, i_bresp};
  assign o_rd_rdy   = ~r_pending & {NUM_RD{r_alive}};
  assign w_cap      = i_rd_req & o_rd_rdy;
  assign w_want     = (r_pending & ~r_issued) | w_cap;
  assign w_ar_hs    = o_arvalid & i_arready;
  assign o_ret_data = i_rdata;
  assign o_ret_last = i_rlast;
  assign o_rready   = 1'b1;
  assign o_bready   = 1'b1;

  // Returns are routed purely by rid; gating on pending drops stray beats after a reset.
  always_comb begin
    o_ret_valid = '0;
    w_r_done    = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      o_ret_valid[j] = i_rvalid & (i_rid == 4'(j)) & r_pending[j];
      w_r_done[j]    = i_rvalid & i_rlast & (i_rid == 4'(j));
    end
  end

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_sel   = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (!w_grant_found && w_want[j] && (4'(j) >= r_rr_ptr)) begin
        w_grant_found = 1'b1;
        w_grant_sel   = 4'(j);
      end
    end
    for (int j = 0; j < NUM_RD; j++) begin
      if (!w_grant_found && w_want[j]) begin
        w_grant_found = 1'b1;
        w_grant_sel   = 4'(j);
      end
    end
    w_g_addr = '0;
    w_g_type = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (r_grant == 4'(j)) begin
        w_g_addr = r_rd_addr[j];
        w_g_type = r_rd_type[j];
      end
    end
  end

  assign w_conflict = (r_w_state != W_IDLE) && ((w_g_addr & LINE_MASK) == (r_wr_addr & LINE_MASK));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_alive   <= 1'b0;
      r_pending <= '0;
      r_issued  <= '0;
      for (int j = 0; j < NUM_RD; j++) begin
        r_rd_addr[j] <= '0;
        r_rd_type[j] <= '0;
      end
    end else begin
      r_alive <= 1'b1;
      for (int j = 0; j < NUM_RD; j++) begin
        if (w_cap[j]) begin
          r_pending[j] <= 1'b1;
          r_issued[j]  <= 1'b0;
          r_rd_addr[j] <= i_rd_addr[32*j +: 32];
          r_rd_type[j] <= i_rd_type[3*j +: 3];
        end else if (w_r_done[j]) begin
          r_pending[j] <= 1'b0;
        end
        if (w_ar_hs && (r_grant == 4'(j))) r_issued[j] <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_ar_state <= AR_IDLE;
    else          r_ar_state <= w_ar_next;
  end

  always_comb begin
    w_ar_next = r_ar_state;
    case (r_ar_state)
      AR_IDLE:  if (w_grant_found) w_ar_next = AR_SEL;
      AR_SEL:   if (!w_conflict)   w_ar_next = AR_VALID;
      AR_VALID: if (i_arready)     w_ar_next = AR_IDLE;
      default:                     w_ar_next = AR_IDLE;
    endcase
  end

  always_comb begin
    o_arvalid = (r_ar_state == AR_VALID);
    o_arid    = r_grant;
    o_arburst = 2'b01;
    o_arlock  = 1'b0;
    o_arcache = 4'd0;
    o_arprot  = 3'd0;
    if (w_g_type[2]) begin
      o_araddr = w_g_addr & LINE_MASK;
      o_arlen  = LINE_LEN;
      o_arsize = 3'd2;
    end else begin
      o_araddr = w_g_addr;
      o_arlen  = 8'd0;
      o_arsize = {1'b0, w_g_type[1:0]};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_ar_state == AR_IDLE && w_grant_found) r_grant <= w_grant_sel;
      if (w_ar_hs) r_rr_ptr <= (r_grant == 4'(NUM_RD - 1)) ? 4'd0 : r_grant + 4'd1;
    end
  end

  assign o_wr_rdy = r_alive & (r_w_state == W_IDLE);
  assign w_wr_cap = i_wr_req & o_wr_rdy;
  assign w_aw_hs  = o_awvalid & i_awready;
  assign w_w_hs   = o_wvalid & i_wready;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | (w_w_hs & o_wlast);

  always_ff @(posedge aclk) begin
    if (!aresetn) r_w_state <= W_IDLE;
    else          r_w_state <= w_w_next;
  end

  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_wr_cap)            w_w_next = W_BUSY;
      W_BUSY:  if (w_aw_fin && w_w_fin) w_w_next = W_RESP;
      W_RESP:  if (i_bvalid)            w_w_next = W_IDLE;
      default:                          w_w_next = W_IDLE;
    endcase
  end

  // AW and W progress independently; each valid drops only after its own handshake.
  always_comb begin
    o_awvalid = (r_w_state == W_BUSY) & ~r_aw_done;
    o_wvalid  = (r_w_state == W_BUSY) & ~r_w_done;
    o_wr_done = (r_w_state == W_RESP) & i_bvalid;
    o_awid    = WR_ID;
    o_wid     = WR_ID;
    o_awburst = 2'b01;
    o_awlock  = 1'b0;
    o_awcache = 4'd0;
    o_awprot  = 3'd0;
    o_wdata   = r_wbuf[r_cnt];
    if (r_wr_type[2]) begin
      o_awaddr = r_wr_addr & LINE_MASK;
      o_awlen  = LINE_LEN;
      o_awsize = 3'd2;
      o_wstrb  = 4'hF;
      o_wlast  = (r_cnt == LAST_BEAT);
    end else begin
      o_awaddr = r_wr_addr;
      o_awlen  = 8'd0;
      o_awsize = {1'b0, r_wr_type[1:0]};
      o_wstrb  = r_wr_wstrb;
      o_wlast  = (r_cnt == '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_type  <= '0;
      r_wr_addr  <= '0;
      r_wr_wstrb <= '0;
      r_cnt      <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      for (int k = 0; k < LINE_WORDS; k++) r_wbuf[k] <= '0;
    end else if (w_wr_cap) begin
      r_wr_type  <= i_wr_type;
      r_wr_addr  <= i_wr_addr;
      r_wr_wstrb <= i_wr_wstrb;
      r_cnt      <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      for (int k = 0; k < LINE_WORDS; k++) r_wbuf[k] <= i_wr_data[32*k +: 32];
    end else if (r_w_state == W_BUSY) begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) begin
        if (o_wlast) r_w_done <= 1'b1;
        else         r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Self-checking bench for axi_cache_bridge: vector table of reads plus hand-written
// write/conflict/arbitration/reset sequences, with AR/AW/W scoreboards.
module tb_axi_cache_bridge;

  localparam int NUM_RD = 2;
  localparam int LW     = 4;

  logic aclk, aresetn;
  logic [NUM_RD-1:0] rdReq, rdRdy, retValid;
  logic [3*NUM_RD-1:0] rdType;
  logic [32*NUM_RD-1:0] rdAddr;
  logic retLast;
  logic [31:0] retData;
  logic wrReq, wrRdy, wrDone;
  logic [2:0] wrType;
  logic [31:0] wrAddr;
  logic [3:0] wrWstrb;
  logic [32*LW-1:0] wrData;
  logic [3:0] arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arlock, awlock, arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic [3:0] arcache, awcache, wstrb;
  logic rlast, rvalid, rready, bvalid, bready;

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; } axExp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wExp_t;
  typedef struct { int id; logic [2:0] ty; logic [31:0] addr; logic [31:0] expAddr; logic [7:0] expLen; logic [2:0] expSize; } rdVec_t;

  axExp_t arQ[$];
  axExp_t awQ[$];
  wExp_t  wQ[$];
  int compared = 0, mismatched = 0;
  int arHs = 0, arPushed = 0;

  axi_cache_bridge #(.NUM_RD(NUM_RD), .LINE_WORDS(LW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_rd_req(rdReq), .i_rd_type(rdType), .i_rd_addr(rdAddr), .o_rd_rdy(rdRdy),
    .o_ret_valid(retValid), .o_ret_last(retLast), .o_ret_data(retData),
    .i_wr_req(wrReq), .i_wr_type(wrType), .i_wr_addr(wrAddr), .i_wr_wstrb(wrWstrb),
    .i_wr_data(wrData), .o_wr_rdy(wrRdy), .o_wr_done(wrDone),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot), .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot), .o_awvalid(awvalid), .i_awready(awready),
    .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard monitors: a handshake completes at the posedge following this sample.
  always @(negedge aclk) begin
    if (arvalid && arready) begin
      axExp_t e;
      checkOutput("ar_expected", 32'(arQ.size() > 0), 1);
      if (arQ.size() > 0) begin
        e = arQ.pop_front();
        checkOutput("arid", arid, e.id);
        checkOutput("araddr", araddr, e.addr);
        checkOutput("arlen", arlen, e.len);
        checkOutput("arsize", arsize, e.size);
        checkOutput("arburst_lock_cache_prot", {arburst, arlock, arcache, arprot}, {2'b01, 8'd0});
      end
      arHs++;
    end
    if (awvalid && awready) begin
      axExp_t e;
      checkOutput("aw_expected", 32'(awQ.size() > 0), 1);
      if (awQ.size() > 0) begin
        e = awQ.pop_front();
        checkOutput("awid", awid, e.id);
        checkOutput("awaddr", awaddr, e.addr);
        checkOutput("awlen", awlen, e.len);
        checkOutput("awsize", awsize, e.size);
        checkOutput("awburst", awburst, 2'b01);
      end
    end
    if (wvalid && wready) begin
      wExp_t e;
      checkOutput("w_expected", 32'(wQ.size() > 0), 1);
      if (wQ.size() > 0) begin
        e = wQ.pop_front();
        checkOutput("wdata", wdata, e.data);
        checkOutput("wstrb", wstrb, e.strb);
        checkOutput("wlast", wlast, e.last);
        checkOutput("wid", wid, NUM_RD);
      end
    end
  end

  task automatic pushAr(input int id, input logic [31:0] a, input logic [7:0] len, input logic [2:0] size);
    arQ.push_back('{4'(id), a, len, size});
    arPushed++;
  endtask

  task automatic waitAr(input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while (arHs < arPushed && k < 60);
    checkOutput({name, "_ar_done"}, 32'(arHs >= arPushed), 1);
  endtask

  task automatic sendR(input int id, input int beats, input logic [31:0] base);
    for (int b = 0; b < beats; b++) begin
      rvalid = 1'b1;
      rid    = 4'(id);
      rdata  = base + 32'(b);
      rlast  = (b == beats - 1);
      @(negedge aclk);
      checkOutput("ret_valid", 32'(retValid), 32'(1 << id));
      checkOutput("ret_data", retData, base + 32'(b));
      checkOutput("ret_last", 32'(retLast), 32'(b == beats - 1));
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    @(negedge aclk);
    checkOutput("rd_rdy_back", 32'(rdRdy[id]), 1);
    tick();
  endtask

  // Drives one read from the table and checks the two-cycle capture-to-arvalid latency.
  task automatic applyStimulus(input rdVec_t v);
    rdReq[v.id]             = 1'b1;
    rdType[3*v.id +: 3]     = v.ty;
    rdAddr[32*v.id +: 32]   = v.addr;
    pushAr(v.id, v.expAddr, v.expLen, v.expSize);
    @(negedge aclk);
    checkOutput("rd_rdy_before", 32'(rdRdy[v.id]), 1);
    tick();
    rdReq = '0;
    @(negedge aclk);
    checkOutput("rd_rdy_busy", 32'(rdRdy[v.id]), 0);
    checkOutput("arvalid_n1", 32'(arvalid), 0);
    tick();
    @(negedge aclk);
    checkOutput("arvalid_n2", 32'(arvalid), 1);
    waitAr("vec");
  endtask

  task automatic writeReq(input logic [2:0] ty, input logic [31:0] a, input logic [3:0] strb, input logic [32*LW-1:0] d);
    wrReq = 1'b1; wrType = ty; wrAddr = a; wrWstrb = strb; wrData = d;
    if (ty[2]) begin
      awQ.push_back('{4'(NUM_RD), a & ~32'hF, 8'd3, 3'd2});
      for (int k = 0; k < LW; k++) wQ.push_back('{d[32*k +: 32], 4'hF, k == LW - 1});
    end else begin
      awQ.push_back('{4'(NUM_RD), a, 8'd0, {1'b0, ty[1:0]}});
      wQ.push_back('{d[31:0], strb, 1'b1});
    end
    tick();
    wrReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rdVec_t vecs[5];
    vecs[0] = '{0, 3'b100, 32'h1C00_0014, 32'h1C00_0010, 8'd3, 3'd2};
    vecs[1] = '{1, 3'b010, 32'h2000_0008, 32'h2000_0008, 8'd0, 3'd2};
    vecs[2] = '{1, 3'b001, 32'h2000_0006, 32'h2000_0006, 8'd0, 3'd1};
    vecs[3] = '{0, 3'b000, 32'h3000_0003, 32'h3000_0003, 8'd0, 3'd0};
    vecs[4] = '{1, 3'b100, 32'h4000_003C, 32'h4000_0030, 8'd3, 3'd2};

    aresetn = 1'b0; rdReq = '0; rdType = '0; rdAddr = '0;
    wrReq = 1'b0; wrType = '0; wrAddr = '0; wrWstrb = '0; wrData = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b1;
    bid = 4'(NUM_RD); bresp = '0; bvalid = 1'b0;

    // Reset values
    repeat (3) tick();
    @(negedge aclk);
    checkOutput("rst_valids", {arvalid, awvalid, wvalid, wrDone}, 0);
    checkOutput("rst_ret_valid", 32'(retValid), 0);
    checkOutput("rst_rd_rdy", 32'(rdRdy), 0);
    checkOutput("rst_wr_rdy", 32'(wrRdy), 0);
    checkOutput("rst_ready", {bready, rready}, 2'b11);
    tick();
    rvalid  = 1'b0;
    aresetn = 1'b1;
    tick();
    @(negedge aclk);
    checkOutput("post_rst_rd_rdy", 32'(rdRdy), 2'b11);
    checkOutput("post_rst_wr_rdy", 32'(wrRdy), 1);
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      sendR(vecs[i].id, int'(vecs[i].expLen) + 1, 32'hD000_0000 | 32'(i << 8));
    end

    // Round robin: pair from ptr 0 goes 0,1; a lone 0 moves ptr to 1; next pair goes 1,0.
    rdReq = 2'b11;
    rdType = {3'b010, 3'b010};
    rdAddr = {32'h6000_0004, 32'h5000_0000};
    pushAr(0, 32'h5000_0000, 8'd0, 3'd2);
    pushAr(1, 32'h6000_0004, 8'd0, 3'd2);
    tick();
    rdReq = '0;
    waitAr("rr_pair1");
    sendR(1, 1, 32'hA100_0000);
    sendR(0, 1, 32'hA000_0000);
    applyStimulus('{0, 3'b010, 32'h5000_0100, 32'h5000_0100, 8'd0, 3'd2});
    sendR(0, 1, 32'hA200_0000);
    rdReq = 2'b11;
    rdAddr = {32'h6000_0008, 32'h5000_0008};
    pushAr(1, 32'h6000_0008, 8'd0, 3'd2);
    pushAr(0, 32'h5000_0008, 8'd0, 3'd2);
    tick();
    rdReq = '0;
    waitAr("rr_pair2");
    sendR(0, 1, 32'hA300_0000);
    sendR(1, 1, 32'hA400_0000);

    // Line write with delayed awready; a same-line read must wait for B.
    awready = 1'b0;
    writeReq(3'b100, 32'h0000_1000, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11});
    @(negedge aclk);
    checkOutput("lw_awvalid_n1", 32'(awvalid), 1);
    checkOutput("lw_wvalid_n1", 32'(wvalid), 1);
    checkOutput("lw_wr_rdy_busy", 32'(wrRdy), 0);
    tick(); tick(); tick();
    awready = 1'b1;
    @(negedge aclk);
    checkOutput("lw_awvalid_held", 32'(awvalid), 1);
    tick();
    @(negedge aclk);
    checkOutput("lw_w_aw_done", {awvalid, wvalid}, 2'b00);
    checkOutput("lw_wr_rdy_resp", 32'(wrRdy), 0);
    tick();
    rdReq[1] = 1'b1;
    rdType[5:3] = 3'b010;
    rdAddr[63:32] = 32'h0000_1008;
    pushAr(1, 32'h0000_1008, 8'd0, 3'd2);
    tick();
    rdReq = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      checkOutput("conflict_hold_arvalid", 32'(arvalid), 0);
      tick();
    end
    bvalid = 1'b1;
    @(negedge aclk);
    checkOutput("lw_wr_done", 32'(wrDone), 1);
    tick();
    bvalid = 1'b0;
    @(negedge aclk);
    checkOutput("lw_wr_rdy_after_b", 32'(wrRdy), 1);
    checkOutput("lw_wr_done_pulse", 32'(wrDone), 0);
    checkOutput("conflict_arvalid_still0", 32'(arvalid), 0);
    waitAr("conflict_read");
    sendR(1, 1, 32'hB000_0000);

    // Byte write, then a read of another line overtakes the outstanding B.
    writeReq(3'b000, 32'h0000_0080, 4'b0100, {96'd0, 32'h00CD_0000});
    @(negedge aclk);
    checkOutput("bw_both_valid", {awvalid, wvalid, wlast}, 3'b111);
    tick();
    @(negedge aclk);
    checkOutput("bw_resp_n2", {awvalid, wvalid}, 2'b00);
    tick();
    applyStimulus('{0, 3'b010, 32'h0000_0100, 32'h0000_0100, 8'd0, 3'd2});
    checkOutput("bw_b_still_pending", 32'(wrRdy), 0);
    sendR(0, 1, 32'hC000_0000);
    bvalid = 1'b1;
    @(negedge aclk);
    checkOutput("bw_wr_done", 32'(wrDone), 1);
    tick();
    bvalid = 1'b0;
    @(negedge aclk);
    checkOutput("bw_wr_rdy", 32'(wrRdy), 1);
    tick();

    // Reset in the middle of an R burst.
    applyStimulus('{0, 3'b100, 32'h7000_0024, 32'h7000_0020, 8'd3, 3'd2});
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rid = 4'd0; rdata = 32'hE000_0000 + 32'(b); rlast = 1'b0;
      @(negedge aclk);
      checkOutput("mid_burst_ret_valid", 32'(retValid), 1);
      tick();
    end
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    checkOutput("mid_rst_ret_valid", 32'(retValid), 0);
    checkOutput("mid_rst_valids", {arvalid, awvalid, wvalid, wrDone}, 0);
    checkOutput("mid_rst_rd_rdy", 32'(rdRdy), 0);
    tick();
    rvalid = 1'b0;
    aresetn = 1'b1;
    tick();
    @(negedge aclk);
    checkOutput("mid_rst_rd_rdy_after", 32'(rdRdy), 2'b11);
    tick();

    checkOutput("arq_empty", 32'(arQ.size()), 0);
    checkOutput("awq_empty", 32'(awQ.size()), 0);
    checkOutput("wq_empty", 32'(wQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
